// File: rtl/axis_noise_gate.sv
// Stereo AXIS noise gate: peak-detects each {L,R} frame, runs an open/hold/release gate, scales samples by gain/256.
// Optional status outputs (gate_state, gate_gain, frame_error) are built when AXIS_NOISE_GATE_STATUS_EN is defined.
module axis_noise_gate #(
  parameter int HOLD_FRAMES  = 64,
  parameter int RELEASE_STEP = 4,
  parameter int GAIN_W       = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        gate_enable,
  input  logic [22:0] open_thresh,
  input  logic [22:0] close_thresh,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  input  logic        s_axis_last,
  output logic [31:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
`ifdef AXIS_NOISE_GATE_STATUS_EN
  output logic [1:0]  gate_state,
  output logic [GAIN_W-1:0] gate_gain,
  output logic        frame_error,
`endif
  output logic        m_axis_last
);

  localparam int FULL_SCALE = 1 << (GAIN_W - 1);
  localparam int HOLD_W     = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(FULL_SCALE);
  localparam logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(RELEASE_STEP);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } gate_state_e;

  // Frame pipeline: capture L, capture R, evaluate gate, multiply, emit L, emit R.
  typedef enum logic [2:0] {
    PH_CAP_L,
    PH_CAP_R,
    PH_EVAL,
    PH_MULT,
    PH_OUT_L,
    PH_OUT_R
  } phase_e;

  phase_e      phase, phase_next;
  gate_state_e state, state_next;
  logic [GAIN_W-1:0] gain, gain_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;

  logic [31:0] l_word, r_word;
  logic [31:0] out_l, out_r;

  logic [22:0] mag_l, mag_r, level;
  logic        level_open, level_low;
  logic [GAIN_W-1:0] gain_dec;
  logic        s_accept;

  // Magnitude with -2^23 saturating to 2^23-1 so it fits the 23-bit threshold domain.
  function automatic logic [22:0] mag24(input logic [23:0] s);
    if (!s[23])
      return s[22:0];
    else if (s[22:0] == '0)
      return '1;
    else
      return 23'(-s);
  endfunction

  // Signed sample times unsigned gain, arithmetic shift by the full-scale exponent (floor).
  function automatic logic [23:0] scale(input logic [23:0] s, input logic [GAIN_W-1:0] g);
    logic signed [GAIN_W+24:0] p;
    p = $signed(s) * $signed({1'b0, g});
    return 24'(p >>> (GAIN_W - 1));
  endfunction

  assign s_axis_ready = (phase == PH_CAP_L) || (phase == PH_CAP_R);
  assign s_accept     = s_axis_valid && s_axis_ready;
  assign m_axis_valid = (phase == PH_OUT_L) || (phase == PH_OUT_R);
  assign m_axis_last  = (phase == PH_OUT_R);
  assign m_axis_data  = (phase == PH_OUT_L) ? out_l :
                        (phase == PH_OUT_R) ? out_r : '0;

  assign mag_l      = mag24(l_word[23:0]);
  assign mag_r      = mag24(r_word[23:0]);
  assign level      = (mag_l > mag_r) ? mag_l : mag_r;
  assign level_open = (level >= open_thresh);
  assign level_low  = (level < close_thresh);
  assign gain_dec   = (gain <= GAIN_STEP) ? '0 : gain - GAIN_STEP;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    phase_next = phase;
    unique case (phase)
      PH_CAP_L: if (s_axis_valid) phase_next = PH_CAP_R;
      PH_CAP_R: if (s_axis_valid) phase_next = PH_EVAL;
      PH_EVAL:  phase_next = PH_MULT;
      PH_MULT:  phase_next = PH_OUT_L;
      PH_OUT_L: if (m_axis_ready) phase_next = PH_OUT_R;
      PH_OUT_R: if (m_axis_ready) phase_next = PH_CAP_L;
      default:  phase_next = PH_CAP_L;
    endcase
  end

  // Gate update: exactly once per frame, in the evaluate cycle.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    hold_next  = hold_cnt;
    if (phase == PH_EVAL) begin
      if (!gate_enable) begin
        state_next = ST_OPEN;
        gain_next  = GAIN_FULL;
        hold_next  = '0;
      end else begin
        unique case (state)
          ST_CLOSED: begin
            if (level_open) begin
              state_next = ST_OPEN;
              gain_next  = GAIN_FULL;
            end else begin
              gain_next  = '0;
            end
          end
          ST_OPEN: begin
            if (level_low) begin
              state_next = ST_HOLD;
              hold_next  = HOLD_INIT;
            end
          end
          ST_HOLD: begin
            if (level_open) begin
              state_next = ST_OPEN;
            end else if (hold_cnt == '0) begin
              state_next = ST_RELEASE;
              gain_next  = gain_dec;
            end else begin
              hold_next  = hold_cnt - HOLD_W'(1);
            end
          end
          ST_RELEASE: begin
            if (level_open) begin
              state_next = ST_OPEN;
              gain_next  = GAIN_FULL;
            end else begin
              gain_next  = gain_dec;
              if (gain_dec == '0) state_next = ST_CLOSED;
            end
          end
          default: state_next = ST_CLOSED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase    <= PH_CAP_L;
      state    <= ST_CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
      l_word   <= '0;
      r_word   <= '0;
      out_l    <= '0;
      out_r    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      phase    <= phase_next;
      state    <= state_next;
      gain     <= gain_next;
      hold_cnt <= hold_next;
      if (s_accept && phase == PH_CAP_L) l_word <= s_axis_data;
      if (s_accept && phase == PH_CAP_R) r_word <= s_axis_data;
      if (phase == PH_MULT) begin
        out_l <= {l_word[31:24], scale(l_word[23:0], gain)};
        out_r <= {r_word[31:24], scale(r_word[23:0], gain)};
      end
    end
  end

`ifdef AXIS_NOISE_GATE_STATUS_EN
  assign gate_state = state;
  assign gate_gain  = gain;

  // Sticky: TLAST must be high exactly on the second word of each frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      frame_error <= 1'b0;
    else if (s_accept && (s_axis_last != (phase == PH_CAP_R)))
      frame_error <= 1'b1;
  end
`else
  // Frames are closed by word count, so TLAST has no consumer in this build.
  logic unused_s_axis_last;
  assign unused_s_axis_last = s_axis_last;
`endif

endmodule

// File: tb/tb_axis_noise_gate.sv
// Self-checking bench for axis_noise_gate: directed vector table, multi-cycle corner sequences, randomized frames vs. a rule model.
module tb_axis_noise_gate;

  localparam int HOLD = 2;
  localparam int STEP = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        gate_enable;
  logic [22:0] open_thresh, close_thresh;
  logic [31:0] s_axis_data;
  logic        s_axis_valid, s_axis_ready, s_axis_last;
  logic [31:0] m_axis_data;
  logic        m_axis_valid, m_axis_ready, m_axis_last;
`ifdef AXIS_NOISE_GATE_STATUS_EN
  logic [1:0]  gate_state;
  logic [8:0]  gate_gain;
  logic        frame_error;
`endif

  always #5 clk = ~clk;

  axis_noise_gate #(.HOLD_FRAMES(HOLD), .RELEASE_STEP(STEP), .GAIN_W(9)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .gate_enable  (gate_enable),
    .open_thresh  (open_thresh),
    .close_thresh (close_thresh),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
`ifdef AXIS_NOISE_GATE_STATUS_EN
    .gate_state   (gate_state),
    .gate_gain    (gate_gain),
    .frame_error  (frame_error),
`endif
    .m_axis_last  (m_axis_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic on the gate rules) ----------------
  int m_mode, m_gain, m_hold;  // mode: 0 closed, 1 open, 2 hold, 3 release

  function automatic int mag(input logic [31:0] w);
    logic signed [23:0] s;
    int v;
    s = w[23:0];
    v = s;
    if (v < 0) v = -v;
    if (v > 'h7FFFFF) v = 'h7FFFFF;
    return v;
  endfunction

  function automatic logic [31:0] scaled(input logic [31:0] w, input int g);
    logic signed [23:0] s;
    longint p;
    s = w[23:0];
    p = longint'(s) * g;
    p = p >>> 8;
    return {w[31:24], p[23:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_gain = 0; m_hold = 0;
  endtask

  task automatic model_frame(input int level, input bit en, input int op, input int cl);
    if (!en) begin
      m_mode = 1; m_gain = 256; m_hold = 0;
    end else begin
      case (m_mode)
        0: if (level >= op) begin m_mode = 1; m_gain = 256; end else m_gain = 0;
        1: if (level < cl) begin m_mode = 2; m_hold = HOLD; end
        2: if (level >= op) m_mode = 1;
           else if (m_hold == 0) begin m_mode = 3; m_gain = (m_gain > STEP) ? m_gain - STEP : 0; end
           else m_hold = m_hold - 1;
        default: if (level >= op) begin m_mode = 1; m_gain = 256; end
                 else begin
                   m_gain = (m_gain > STEP) ? m_gain - STEP : 0;
                   if (m_gain == 0) m_mode = 0;
                 end
      endcase
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input string nm);
    int n = 0;
    @(negedge clk);
    s_axis_data = d; s_axis_last = last; s_axis_valid = 1'b1;
    while (!s_axis_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_axis_ready) check({nm, " ready timeout"}, 32'(s_axis_ready), 32'd1);
    @(posedge clk);
    #1 s_axis_valid = 1'b0;
  endtask

  task automatic recv_frame(input logic [31:0] el, input logic [31:0] er, input int stall,
                            input string nm, input bit chk_lat);
    int n = 0;
    while (!m_axis_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (chk_lat) check({nm, " latency"}, 32'(n), 32'd2);
    else if (!m_axis_valid) check({nm, " valid timeout"}, 32'(m_axis_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      check({nm, " stall data"}, m_axis_data, el);
      check({nm, " stall s_ready"}, 32'(s_axis_ready), 32'd0);
      check({nm, " stall last"}, 32'(m_axis_last), 32'd0);
      @(posedge clk); #1;
    end
    m_axis_ready = 1'b1;
    check({nm, " L data"}, m_axis_data, el);
    check({nm, " L last"}, 32'(m_axis_last), 32'd0);
    @(posedge clk); #1;
    check({nm, " R valid"}, 32'(m_axis_valid), 32'd1);
    check({nm, " R last"}, 32'(m_axis_last), 32'd1);
    check({nm, " R data"}, m_axis_data, er);
    @(posedge clk); #1;
    check({nm, " end valid"}, 32'(m_axis_valid), 32'd0);
    check({nm, " end s_ready"}, 32'(s_axis_ready), 32'd1);
    m_axis_ready = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] l, input logic [31:0] r, input logic en,
                      input logic [22:0] op, input logic [22:0] cl,
                      input logic [31:0] el, input logic [31:0] er,
                      input int stall, input string nm, input bit chk_lat);
    gate_enable = en; open_thresh = op; close_thresh = cl;
    send_word(l, 1'b0, nm);
    send_word(r, 1'b1, nm);
    recv_frame(el, er, stall, nm, chk_lat);
  endtask

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        en;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] l, r, el, er;
    logic [22:0] op, cl;
    bit en;
    int lvl;

    // open=0x100000, close=0x080000, HOLD=2, STEP=64; vectors run in order from reset.
    tbl[0]  = '{32'h34000050, 32'h56FFFFB0, 1'b1, 32'h34000000, 32'h56000000}; // stays closed
    tbl[1]  = '{32'h00200000, 32'h00000000, 1'b1, 32'h00200000, 32'h00000000}; // opens
    tbl[2]  = '{32'h00E00001, 32'h00100000, 1'b1, 32'h00E00001, 32'h00100000}; // negative passthrough
    tbl[3]  = '{32'h00010000, 32'h00FF0000, 1'b1, 32'h00010000, 32'h00FF0000}; // hold, 256
    tbl[4]  = '{32'h11010000, 32'h22FF0000, 1'b1, 32'h11010000, 32'h22FF0000}; // hold, 256
    tbl[5]  = '{32'h00010000, 32'h00FF0000, 1'b1, 32'h00010000, 32'h00FF0000}; // hold, 256
    tbl[6]  = '{32'h00010000, 32'h00FF0000, 1'b1, 32'h0000C000, 32'h00FF4000}; // release 192
    tbl[7]  = '{32'h00010000, 32'h00FFFFFF, 1'b1, 32'h00008000, 32'h00FFFFFF}; // 128, floor of -0.5
    tbl[8]  = '{32'h007FFFFF, 32'h00800000, 1'b1, 32'h007FFFFF, 32'h00800000}; // reopen, saturated peak
    tbl[9]  = '{32'h00010000, 32'h00000000, 1'b1, 32'h00010000, 32'h00000000};
    tbl[10] = '{32'h00010000, 32'h00000000, 1'b1, 32'h00010000, 32'h00000000};
    tbl[11] = '{32'h00010000, 32'h00000000, 1'b1, 32'h00010000, 32'h00000000};
    tbl[12] = '{32'h00010000, 32'h00000000, 1'b1, 32'h0000C000, 32'h00000000}; // 192
    tbl[13] = '{32'h00010000, 32'h00000000, 1'b1, 32'h00008000, 32'h00000000}; // 128
    tbl[14] = '{32'h00010000, 32'h00000003, 1'b1, 32'h00004000, 32'h00000000}; // 64
    tbl[15] = '{32'h00010000, 32'h00FFFFFF, 1'b1, 32'h00000000, 32'h00000000}; // 0 -> closed
    tbl[16] = '{32'h000C0000, 32'hAA000000, 1'b1, 32'h00000000, 32'hAA000000}; // between thresholds
    tbl[17] = '{32'h00100000, 32'h00000000, 1'b1, 32'h00100000, 32'h00000000}; // level == open
    tbl[18] = '{32'h00080000, 32'h00F80000, 1'b1, 32'h00080000, 32'h00F80000}; // level == close
    tbl[19] = '{32'h0007FFFF, 32'h00000001, 1'b1, 32'h0007FFFF, 32'h00000001}; // below close -> hold
    tbl[20] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h12345678, 32'h9ABCDEF0}; // bypass forces open
    tbl[21] = '{32'h00000010, 32'h00000000, 1'b1, 32'h00000010, 32'h00000000}; // open -> hold

    resetn = 1'b0;
    gate_enable = 1'b0; open_thresh = '0; close_thresh = '0;
    s_axis_data = '0; s_axis_valid = 1'b0; s_axis_last = 1'b0; m_axis_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset s_ready", 32'(s_axis_ready), 32'd1);
    check("reset m_valid", 32'(m_axis_valid), 32'd0);
    check("reset m_last", 32'(m_axis_last), 32'd0);
    check("reset m_data", m_axis_data, 32'd0);
    resetn = 1'b1;

    // Bypass: bit-exact including side bits, 2-clock latency.
    xfer(32'h12800001, 32'hAB7FFFFF, 1'b0, 23'h100000, 23'h080000,
         32'h12800001, 32'hAB7FFFFF, 0, "bypass", 1'b1);

    do_reset();
    for (int i = 0; i < 22; i++)
      xfer(tbl[i].l, tbl[i].r, tbl[i].en, 23'h100000, 23'h080000,
           tbl[i].el, tbl[i].er, 0, $sformatf("vec%0d", i), 1'b1);

    // Downstream backpressure: data/last held, input side stalled.
    xfer(32'h5A123456, 32'hA5FEDCBA, 1'b0, 23'h100000, 23'h080000,
         32'h5A123456, 32'hA5FEDCBA, 5, "stall", 1'b1);

    // Reset during output: everything returns to idle immediately.
    gate_enable = 1'b0;
    send_word(32'h01000001, 1'b0, "rst_out");
    send_word(32'h02000002, 1'b1, "rst_out");
    repeat (3) @(posedge clk);
    #1 check("pre-reset valid", 32'(m_axis_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("async rst m_valid", 32'(m_axis_valid), 32'd0);
    check("async rst m_data", m_axis_data, 32'd0);
    check("async rst s_ready", 32'(s_axis_ready), 32'd1);
    @(negedge clk); resetn = 1'b1;

    // Reset after L accepted: partial frame discarded, next word is L again.
    send_word(32'h0A0000AA, 1'b0, "rst_mid");
    @(negedge clk); resetn = 1'b0;
    #1 check("mid rst m_last", 32'(m_axis_last), 32'd0);
    @(negedge clk); resetn = 1'b1;
    xfer(32'h0B0000BB, 32'h0C0000CC, 1'b0, 23'h100000, 23'h080000,
         32'h0B0000BB, 32'h0C0000CC, 0, "post_rst", 1'b1);

    // Randomized frames checked against the model.
    do_reset();
    model_reset();
    for (int f = 0; f < 60; f++) begin
      en = ($urandom_range(0, 9) != 0);
      op = 23'($urandom_range(32'h400000, 32'h010000));
      cl = ($urandom_range(0, 7) == 0) ? 23'($urandom_range(32'h7FFFFF, 32'h0))
                                       : 23'($urandom_range(32'(op), 32'(op) / 8));
      l = $urandom;
      r = $urandom;
      l[23:0] = l[23:0] >> $urandom_range(0, 6);
      r[23:0] = r[23:0] >> $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) l[23:0] = -l[23:0];
      if ($urandom_range(0, 15) == 0) r[23:0] = 24'h800000;
      lvl = (mag(l) > mag(r)) ? mag(l) : mag(r);
      model_frame(lvl, en, int'(op), int'(cl));
      el = scaled(l, m_gain);
      er = scaled(r, m_gain);
      xfer(l, r, en, op, cl, el, er, $urandom_range(0, 2), $sformatf("rand%0d", f), 1'b0);
`ifdef AXIS_NOISE_GATE_STATUS_EN
      check($sformatf("rand%0d gain", f), 32'(gate_gain), 32'(m_gain));
      check($sformatf("rand%0d state", f), 32'(gate_state), 32'(m_mode));
      check($sformatf("rand%0d frame_error", f), 32'(frame_error), 32'd0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
